// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative forward AES MixColumns engine.
//
// Accepts one 128-bit state over in_valid/in_ready. It transforms
// COLS_PER_CYCLE columns per clock with the fixed matrix {02 03 01 01}
// over GF(2^8), then presents the result over out_valid/out_ready.
// in_bypass (final round) passes the state through unchanged, with the
// same timing as a transformed state.
//
// Ports:
//   clk        clock, rising-edge
//   rst        synchronous reset, active-high
//   in_valid   in_data/in_bypass valid
//   in_ready   engine idle and able to accept a state
//   in_data    input state; column c = in_data[127-32c -: 32], row 0 = MSB byte
//   in_bypass  skip the transform for this state
//   out_valid  out_data valid, held until out_ready
//   out_ready  downstream accepts out_data
//   out_data   result state, same layout as in_data
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int N = 4 / COLS_PER_CYCLE;

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Index [3] holds column 0 so the packed vector matches in_data's layout.
    logic [3:0][31:0] work_q, work_d;
    logic             byp_q;
    logic [1:0]       idx_q;
    logic [1:0]       cnt_q;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Column units: unit g works on column idx_q+g; the 2-bit sum wraps 3->0.
    logic [1:0]  sel   [COLS_PER_CYCLE];
    logic [31:0] mixed [COLS_PER_CYCLE];

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
            assign sel[g]   = idx_q + 2'(g);
            assign mixed[g] = mix_col(work_q[~sel[g]]);
        end
    endgenerate

    always_comb begin
        work_d = work_q;
        if (!byp_q) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                work_d[~sel[g]] = mixed[g];
            end
        end
    end

    // FSM: the cycle counter, not the index wrap, ends BUSY, because with
    // four columns per cycle the index wraps on every cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (cnt_q == 2'(N - 1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= '0;
            byp_q  <= 1'b0;
            idx_q  <= 2'd0;
            cnt_q  <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q <= in_data;
                        byp_q  <= in_bypass;
                        idx_q  <= 2'd0;
                        cnt_q  <= 2'd0;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    idx_q  <= idx_q + 2'(COLS_PER_CYCLE);
                    cnt_q  <= cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low combinationally while rst is high.
    assign in_ready  = !rst && (state_q == IDLE);
    assign out_valid = !rst && (state_q == DONE);
    assign out_data  = rst ? '0 : work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: bench for mix_columns_seq at COLS_PER_CYCLE = 1, 2, 4.
// Three instances share clk/rst. Each has its own handshake signals and is
// exercised in turn. Expected states come from fixed vectors or from a
// matrix-times-column model built on carry-less GF(2^8) multiplication.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         in_bypass [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_data   (in_data[g]),
                .in_bypass (in_bypass[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_data  (out_data[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Carry-less product, then reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix: row i, column j coefficient depends on (j-i) mod 4.
    function automatic logic [7:0] coef(input int i, input int j);
        case ((j - i) & 3)
            0:       return 8'h02;
            1:       return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic byp);
        logic [127:0] r;
        logic [7:0]   acc;
        if (byp) return s;
        r = s;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef(i, j), s[127 - 32*c - 8*j -: 8]);
                r[127 - 32*c - 8*i -: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Send one state, measure latency from the accept cycle, optionally hold
    // out_ready low for 'hold' cycles while in_valid toggles with junk data.
    task automatic xfer(input int u, input logic [127:0] d, input logic b, input int hold,
                        output logic [127:0] got, output int lat);
        int w;
        in_data[u] = d; in_bypass[u] = b; in_valid[u] = 1'b1;
        out_ready[u] = (hold == 0);
        w = 0;
        while (!in_ready[u] && w < 20) begin @(negedge clk); w++; end
        if (w >= 20) chk($sformatf("u%0d accept_timeout", u), w, 0);
        @(negedge clk);
        in_valid[u] = 1'b0; in_data[u] = rnd128(); in_bypass[u] = ~b;
        lat = 1;
        while (!out_valid[u] && lat < 20) begin @(negedge clk); lat++; end
        got = out_data[u];
        for (int i = 0; i < hold; i++) begin
            in_valid[u] = 1'($urandom % 2); in_data[u] = rnd128();
            @(negedge clk);
            chk($sformatf("u%0d bp_valid", u), out_valid[u], 1);
            chk($sformatf("u%0d bp_data", u), out_data[u], got);
            chk($sformatf("u%0d bp_in_ready", u), in_ready[u], 0);
        end
        // in_valid high alongside the releasing out_ready must not be taken.
        in_valid[u] = (hold > 0); out_ready[u] = 1'b1;
        @(negedge clk);
        chk($sformatf("u%0d released_valid", u), out_valid[u], 0);
        chk($sformatf("u%0d idle_in_ready", u), in_ready[u], 1);
        in_valid[u] = 1'b0; out_ready[u] = 1'b0;
    endtask

    task automatic run_vec(input int u, input string tag, input logic [127:0] d,
                           input logic b, input logic [127:0] exp);
        logic [127:0] got;
        int lat;
        xfer(u, d, b, 0, got, lat);
        chk($sformatf("u%0d %s data", u, tag), got, exp);
        chk($sformatf("u%0d %s latency", u, tag), lat, (4 >> u) + 1);
    endtask

    task automatic rst_mid(input int u);
        int w, seen;
        logic [127:0] d, got;
        int lat;
        in_data[u] = rnd128(); in_bypass[u] = 1'b0; in_valid[u] = 1'b1;
        w = 0;
        while (!in_ready[u] && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        in_valid[u] = 1'b0;
        rst = 1'b1;
        #1;
        chk($sformatf("u%0d rst_out_valid", u), out_valid[u], 0);
        chk($sformatf("u%0d rst_out_data", u), out_data[u], 0);
        chk($sformatf("u%0d rst_in_ready", u), in_ready[u], 0);
        @(negedge clk);
        chk($sformatf("u%0d rst_hold_in_ready", u), in_ready[u], 0);
        rst = 1'b0;
        #1;
        chk($sformatf("u%0d post_rst_in_ready", u), in_ready[u], 1);
        seen = 0;
        for (int i = 0; i < (4 >> u) + 3; i++) begin
            @(negedge clk);
            if (out_valid[u]) seen++;
        end
        chk($sformatf("u%0d aborted_no_output", u), seen, 0);
        d = rnd128();
        xfer(u, d, 1'b0, 0, got, lat);
        chk($sformatf("u%0d after_rst_data", u), got, mix_ref(d, 1'b0));
    endtask

    task automatic b2b(input int u);
        logic [127:0] exp_q[$];
        int acc_q[$];
        int sent, gotn, budget;
        logic pending;
        logic [127:0] d;
        logic b;
        sent = 0; gotn = 0; budget = 0; pending = 1'b0;
        out_ready[u] = 1'b1;
        d = rnd128(); b = ($urandom % 4 == 0);
        in_data[u] = d; in_bypass[u] = b; in_valid[u] = 1'b1;
        while (gotn < 8 && budget < 300) begin
            if (in_valid[u] && in_ready[u]) begin
                acc_q.push_back(cyc);
                exp_q.push_back(mix_ref(d, b));
                sent++;
                pending = 1'b1;
            end
            @(negedge clk);
            budget++;
            if (pending) begin
                pending = 1'b0;
                if (sent < 8) begin
                    d = rnd128(); b = ($urandom % 4 == 0);
                    in_data[u] = d; in_bypass[u] = b;
                end else begin
                    in_valid[u] = 1'b0;
                end
            end
            if (out_valid[u] && exp_q.size() > 0) begin
                chk($sformatf("u%0d b2b_data%0d", u, gotn), out_data[u], exp_q.pop_front());
                gotn++;
            end
        end
        if (gotn < 8) chk($sformatf("u%0d b2b_timeout", u), gotn, 8);
        for (int i = 1; i < acc_q.size(); i++)
            chk($sformatf("u%0d b2b_spacing%0d", u, i), acc_q[i] - acc_q[i-1], (4 >> u) + 2);
        in_valid[u] = 1'b0; out_ready[u] = 1'b0;
    endtask

    initial begin
        logic [127:0] d, got;
        int lat;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; in_data[u] = '0; in_bypass[u] = 1'b0; out_ready[u] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("u%0d reset_out_valid", u), out_valid[u], 0);
            chk($sformatf("u%0d reset_out_data", u), out_data[u], 0);
            chk($sformatf("u%0d reset_in_ready", u), in_ready[u], 0);
        end
        rst = 1'b0;
        #1;
        for (int u = 0; u < 3; u++)
            chk($sformatf("u%0d release_in_ready", u), in_ready[u], 1);
        @(negedge clk);

        for (int u = 0; u < 3; u++) begin
            run_vec(u, "fips", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
                    128'h046681e5e0cb199a48f8d37a2806264c);
            run_vec(u, "known", 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0,
                    128'h8e4da1bc9fdc589d01010101c6c6c6c6);
            run_vec(u, "bypass1", 128'hd4d4d4d52d26314c00000000ffffffff, 1'b1,
                    128'hd4d4d4d52d26314c00000000ffffffff);
            run_vec(u, "bypass0", 128'hd4d4d4d52d26314c00000000ffffffff, 1'b0,
                    128'hd5d5d7d64d7ebdf800000000ffffffff);
            d = rnd128();
            xfer(u, d, 1'b0, 10, got, lat);
            chk($sformatf("u%0d backpressure_data", u), got, mix_ref(d, 1'b0));
            chk($sformatf("u%0d backpressure_latency", u), lat, (4 >> u) + 1);
            rst_mid(u);
            b2b(u);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d checks expected completion", n_chk);
        $fatal(1, "timeout");
    end

endmodule
